// File: rtl/sobel_pkg.sv
// Shared constants and state encoding for the Sobel frame sequencer.
package sobel_pkg;
  localparam int WIDTH  = 640;
  localparam int HEIGHT = 480;
  localparam int N      = WIDTH * HEIGHT;
  localparam int ADDR_W = 19;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;
endpackage

// File: rtl/filter_frame_ctrl_if.sv
// Filter-side bus: input bank select, pass start, read/write address streams.
interface filter_frame_ctrl_if;
  import sobel_pkg::*;

  logic              filt_bank;
  logic              filt_start;
  logic [ADDR_W-1:0] filt_read_addr;
  logic              filt_write_en;
  logic [ADDR_W-1:0] filt_write_addr;
  logic              filt_border;

  modport master (output filt_bank, filt_start, filt_read_addr,
                         filt_write_en, filt_write_addr, filt_border);
  modport slave  (input  filt_bank, filt_start, filt_read_addr,
                         filt_write_en, filt_write_addr, filt_border);
endinterface

// File: rtl/pixel_pos_counter.sv
// Row/col tracker for a raster scan; border flag is registered with the position.
module pixel_pos_counter #(
  parameter  int WIDTH  = 640,
  parameter  int HEIGHT = 480,
  localparam int CW     = (WIDTH  > 1) ? $clog2(WIDTH)  : 1,
  localparam int RW     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          advance,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          border
);
  logic [CW-1:0] col_nxt;
  logic [RW-1:0] row_nxt;

  // next position: clear wins, else step with wrap at line/frame end
  always_comb begin
    col_nxt = col;
    row_nxt = row;
    if (clear) begin
      col_nxt = '0;
      row_nxt = '0;
    end else if (advance) begin
      if (col == CW'(WIDTH - 1)) begin
        col_nxt = '0;
        row_nxt = (row == RW'(HEIGHT - 1)) ? '0 : row + 1'b1;
      end else begin
        col_nxt = col + 1'b1;
      end
    end
  end

  // position and border flag move together so border lines up with the pixel
  always_ff @(posedge clk) begin
    if (rst) begin
      col    <= '0;
      row    <= '0;
      border <= 1'b0;
    end else begin
      col <= col_nxt;
      row <= row_nxt;
      if (clear || advance)
        border <= (col_nxt == '0) || (col_nxt == CW'(WIDTH - 1)) ||
                  (row_nxt == '0) || (row_nxt == RW'(HEIGHT - 1));
    end
  end
endmodule

// File: rtl/filter_frame_ctrl.sv
// Frame sequencer: bank ping-pong, filter read/write address generation with
// latency compensation, border flagging and a one-deep start queue with drop count.
module filter_frame_ctrl import sobel_pkg::*; #(
  parameter int WIDTH   = sobel_pkg::WIDTH,
  parameter int HEIGHT  = sobel_pkg::HEIGHT,
  parameter int LATENCY = 642
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       cam_frame_done,
  output logic       cam_bank,
  output logic       out_wr_bank,
  output logic       disp_bank,
  output logic       busy,
  output logic [7:0] drop_count,
  filter_frame_ctrl_if.master filt
);
  localparam int                NPIX   = WIDTH * HEIGHT;
  localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(NPIX - 1);
  localparam logic [ADDR_W:0]   LAT_M1 = (ADDR_W + 1)'(LATENCY - 1);

  state_t            state;
  logic              pending;
  logic [ADDR_W:0]   pc;       // pass cycle, only counted until writing begins
  logic              filt_bank_q, start_q, wr_en_q;
  logic [ADDR_W-1:0] rd_q, wr_q;
  logic              launch, pos_clear, pos_adv, pos_border;
  logic [((WIDTH  > 1) ? $clog2(WIDTH)  : 1)-1:0] pos_col;
  logic [((HEIGHT > 1) ? $clog2(HEIGHT) : 1)-1:0] pos_row;

  assign launch    = (state == IDLE) && enable && (cam_frame_done || pending);
  assign pos_clear = (state != IDLE) && !wr_en_q && (pc == LAT_M1);
  assign pos_adv   = (state != IDLE) && wr_en_q && (wr_q != LAST);

  // pass sequencing, address streams, bank swaps and frame queueing
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cam_bank    <= 1'b0;
      filt_bank_q <= 1'b1;
      disp_bank   <= 1'b0;
      out_wr_bank <= 1'b1;
      busy        <= 1'b0;
      start_q     <= 1'b0;
      rd_q        <= '0;
      wr_en_q     <= 1'b0;
      wr_q        <= '0;
      pc          <= '0;
      pending     <= 1'b0;
      drop_count  <= '0;
    end else begin
      start_q <= 1'b0;
      // a frame that cannot start now is queued once; further ones are dropped
      if (cam_frame_done && !launch) begin
        if (!pending)                 pending    <= 1'b1;
        else if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      end
      case (state)
        IDLE: begin
          if (launch) begin
            state       <= RUN;
            busy        <= 1'b1;
            start_q     <= 1'b1;
            cam_bank    <= ~cam_bank;
            filt_bank_q <= ~filt_bank_q;
            pending     <= 1'b0;
            rd_q        <= '0;
            pc          <= '0;
          end
        end
        RUN, FLUSH: begin
          if (state == RUN) begin
            if (rd_q == LAST) state <= FLUSH;
            else              rd_q  <= rd_q + 1'b1;
          end
          if (!wr_en_q) begin
            pc <= pc + 1'b1;
            if (pc == LAT_M1) wr_en_q <= 1'b1;
          end else if (wr_q == LAST) begin
            state       <= IDLE;
            busy        <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_q        <= '0;
            rd_q        <= '0;
            disp_bank   <= ~disp_bank;
            out_wr_bank <= ~out_wr_bank;
          end else begin
            wr_q <= wr_q + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  pixel_pos_counter #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_wr_pos (
    .clk    (clk),
    .rst    (rst),
    .clear  (pos_clear),
    .advance(pos_adv),
    .col    (pos_col),
    .row    (pos_row),
    .border (pos_border)
  );

  assign filt.filt_bank       = filt_bank_q;
  assign filt.filt_start      = start_q;
  assign filt.filt_read_addr  = rd_q;
  assign filt.filt_write_en   = wr_en_q;
  assign filt.filt_write_addr = wr_q;
  assign filt.filt_border     = wr_en_q & pos_border;
endmodule

// File: tb/tb_filter_frame_ctrl.sv
// Bench for filter_frame_ctrl on an 8x4 frame with LATENCY 10.
module tb_filter_frame_ctrl;
  localparam int W = 8, H = 4, LAT = 10, NP = W * H;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b1;
  logic       cam_frame_done = 1'b0;
  logic       cam_bank, out_wr_bank, disp_bank, busy;
  logic [7:0] drop_count;

  filter_frame_ctrl_if fif ();

  filter_frame_ctrl #(.WIDTH(W), .HEIGHT(H), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .enable(enable), .cam_frame_done(cam_frame_done),
    .cam_bank(cam_bank), .out_wr_bank(out_wr_bank), .disp_bank(disp_bank),
    .busy(busy), .drop_count(drop_count), .filt(fif)
  );

  always #5 clk = ~clk;

  typedef struct {
    int k; int start; int bsy; int rd; int wen; int wa; int brd;
    int cam; int filt; int disp; int owr;
  } vec_t;

  typedef struct { int addr; int border; } sb_t;

  int  errors = 0, checks = 0, cyc = 0;
  int  border_hits = 0, wr_count = 0;
  sb_t sbq[$];
  vec_t tv[7];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int border_of(input int a);
    int r, c;
    r = a / W; c = a % W;
    return (r == 0 || r == H - 1 || c == 0 || c == W - 1) ? 1 : 0;
  endfunction

  task automatic push_pass();
    for (int a = 0; a < NP; a++) sbq.push_back('{a, border_of(a)});
  endtask

  // one clock; outputs sampled on the falling edge, scoreboard checks writes
  task automatic tick();
    sb_t e;
    @(posedge clk); cyc++;
    @(negedge clk);
    if (!rst && fif.filt_write_en) begin
      wr_count++;
      if (fif.filt_border) border_hits++;
      if (sbq.size() == 0) chk("sb_unexpected_write", 1, 0);
      else begin
        e = sbq.pop_front();
        chk("sb_waddr", int'(fif.filt_write_addr), e.addr);
        chk("sb_border", int'(fif.filt_border), e.border);
      end
    end
  endtask

  task automatic pulse();
    cam_frame_done = 1'b1; tick(); cam_frame_done = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0; sbq.delete();
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin tick(); n++; end
    if (busy) chk("timeout_idle", 1, 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},  int'(busy), 0);
    chk({tag, "_start"}, int'(fif.filt_start), 0);
    chk({tag, "_wen"},   int'(fif.filt_write_en), 0);
    chk({tag, "_waddr"}, int'(fif.filt_write_addr), 0);
    chk({tag, "_raddr"}, int'(fif.filt_read_addr), 0);
    chk({tag, "_border"},int'(fif.filt_border), 0);
    chk({tag, "_cam"},   int'(cam_bank), 0);
    chk({tag, "_fbank"}, int'(fif.filt_bank), 1);
    chk({tag, "_disp"},  int'(disp_bank), 0);
    chk({tag, "_owr"},   int'(out_wr_bank), 1);
    chk({tag, "_drop"},  int'(drop_count), 0);
  endtask

  initial begin
    int starts, lastw, startc, n;
    //        k  st bsy  rd wen  wa brd cam flt dsp owr   (rd -1 = don't care)
    tv[0] = '{ 1, 1, 1,  0, 0,  0, 0,  1,  0,  0,  1};
    tv[1] = '{ 2, 0, 1,  1, 0,  0, 0,  1,  0,  0,  1};
    tv[2] = '{11, 0, 1, 10, 1,  0, 1,  1,  0,  0,  1};
    tv[3] = '{32, 0, 1, 31, 1, 21, 0,  1,  0,  0,  1};
    tv[4] = '{33, 0, 1, 31, 1, 22, 0,  1,  0,  0,  1};
    tv[5] = '{42, 0, 1, 31, 1, 31, 1,  1,  0,  0,  1};
    tv[6] = '{43, 0, 0, -1, 0,  0, 0,  1,  0,  1,  0};

    do_reset();
    chk_reset_outputs("rst");

    // single pass, timing table
    border_hits = 0; wr_count = 0;
    push_pass();
    pulse();
    for (int k = 1; k <= 43; k++) begin
      if (k > 1) tick();
      if (k <= 42) chk("raddr", int'(fif.filt_read_addr), (k - 1 < NP - 1) ? k - 1 : NP - 1);
      for (int i = 0; i < 7; i++) if (tv[i].k == k) begin
        chk("tv_start", int'(fif.filt_start), tv[i].start);
        chk("tv_busy",  int'(busy), tv[i].bsy);
        if (tv[i].rd >= 0) chk("tv_raddr", int'(fif.filt_read_addr), tv[i].rd);
        chk("tv_wen",   int'(fif.filt_write_en), tv[i].wen);
        chk("tv_waddr", int'(fif.filt_write_addr), tv[i].wa);
        chk("tv_border",int'(fif.filt_border), tv[i].brd);
        chk("tv_cam",   int'(cam_bank), tv[i].cam);
        chk("tv_fbank", int'(fif.filt_bank), tv[i].filt);
        chk("tv_disp",  int'(disp_bank), tv[i].disp);
        chk("tv_owr",   int'(out_wr_bank), tv[i].owr);
      end
    end
    chk("border_count", border_hits, 20);
    chk("write_count", wr_count, NP);
    chk("sb_drained_1", sbq.size(), 0);

    // frame arriving mid-pass is queued; one idle cycle between passes
    do_reset();
    push_pass(); pulse();
    for (int i = 0; i < 3; i++) tick();
    push_pass(); pulse();
    lastw = -1; startc = -1; n = 0;
    while (startc < 0 && n < 200) begin
      tick(); n++;
      if (lastw < 0 && fif.filt_write_en && fif.filt_write_addr == 19'(NP - 1)) lastw = cyc;
      else if (lastw >= 0 && cyc == lastw + 1) chk("gap_busy", int'(busy), 0);
      if (lastw >= 0 && fif.filt_start) startc = cyc;
    end
    chk("pass_gap", startc - lastw, 2);
    chk("q_cam", int'(cam_bank), 0);
    chk("q_fbank", int'(fif.filt_bank), 1);
    chk("q_drop", int'(drop_count), 0);
    wait_idle(100);
    chk("q_disp", int'(disp_bank), 0);
    chk("sb_drained_2", sbq.size(), 0);

    // three frames in one pass: two dropped, exactly one queued pass
    do_reset();
    push_pass(); pulse();
    tick(); push_pass(); pulse();
    tick(); pulse();
    tick(); pulse();
    starts = 0;
    for (int i = 0; i < 150; i++) begin tick(); if (fif.filt_start) starts++; end
    chk("drop_starts", starts, 1);
    chk("drop_count", int'(drop_count), 2);
    chk("drop_busy", int'(busy), 0);
    chk("sb_drained_3", sbq.size(), 0);

    // enable low holds the frame until enable rises
    do_reset();
    enable = 1'b0;
    pulse();
    starts = 0;
    for (int i = 0; i < 4; i++) begin tick(); if (fif.filt_start) starts++; end
    chk("en_low_starts", starts + int'(busy), 0);
    enable = 1'b1; push_pass();
    tick();
    chk("en_start", int'(fif.filt_start), 1);
    wait_idle(100);
    chk("sb_drained_4", sbq.size(), 0);

    // reset mid-pass at write address 20
    do_reset();
    push_pass(); pulse();
    pulse();
    tick(); pulse();
    n = 0;
    while (!(fif.filt_write_en && fif.filt_write_addr == 19'd20) && n < 100) begin tick(); n++; end
    chk("reach_w20", int'(fif.filt_write_addr), 20);
    chk("pre_rst_drop", int'(drop_count), 1);
    rst = 1'b1;
    tick();
    chk_reset_outputs("midrst");
    sbq.delete();
    rst = 1'b0;
    starts = 0;
    for (int i = 0; i < 30; i++) begin tick(); if (fif.filt_start) starts++; end
    chk("post_rst_starts", starts, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
